// File: rtl/rstmgr_seq.sv
// Sequenced reset manager: merges reset requests, holds all domains in reset
// for MinHold quiet cycles, then releases domains in ascending order SeqGap apart.
module rstmgr_seq #(
    parameter int NumDomains = 4,
    parameter int NumReqs    = 2,
    parameter int SyncStages = 2,
    parameter int MinHold    = 8,
    parameter int SeqGap     = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [NumReqs-1:0]    rst_req_i,
    input  logic                  sw_rst_req_i,
    input  logic                  cause_clr_i,
    output logic [NumDomains-1:0] domain_rst_no,
    output logic                  rst_done_o,
    output logic [NumReqs+1:0]    rst_cause_o,
    output logic [1:0]            fsm_state
);

    typedef enum logic [1:0] {
        ST_ASSERT  = 2'd0,
        ST_RELEASE = 2'd1,
        ST_RUN     = 2'd2
    } state_e;

    localparam int CW = $clog2(MinHold + 1);
    localparam int GW = $clog2(SeqGap + 1);
    localparam int IW = $clog2(NumDomains + 1);

    localparam logic [CW-1:0] HOLD_LAST = CW'(MinHold - 1);
    localparam logic [GW-1:0] GAP_LAST  = GW'(SeqGap - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(NumDomains - 1);

    logic [NumReqs-1:0]    sync_q [SyncStages];
    logic [NumReqs-1:0]    req_sync;
    logic                  req_s;

    state_e                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [GW-1:0]         gap_q, gap_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [NumDomains-1:0] drst_q, drst_d;
    logic                  done_q, done_d;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int s = 0; s < SyncStages; s++) sync_q[s] <= '0;
        end else begin
            sync_q[0] <= rst_req_i;
            for (int s = 1; s < SyncStages; s++) sync_q[s] <= sync_q[s-1];
        end
    end

    assign req_sync = sync_q[SyncStages-1];
    // The software pulse is already clk_i-synchronous, so it bypasses the synchroniser.
    assign req_s    = (|req_sync) | sw_rst_req_i;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        gap_d   = gap_q;
        idx_d   = idx_q;
        drst_d  = drst_q;
        done_d  = done_q;
        case (state_q)
            ST_ASSERT: begin
                drst_d = '0;
                done_d = 1'b0;
                if (req_s) begin
                    cnt_d = '0;
                end else if (cnt_q == HOLD_LAST) begin
                    state_d = ST_RELEASE;
                    drst_d  = NumDomains'(1);
                    idx_d   = '0;
                    gap_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_RELEASE: begin
                if (req_s) begin
                    state_d = ST_ASSERT;
                    drst_d  = '0;
                    done_d  = 1'b0;
                    cnt_d   = '0;
                end else if (gap_q == GAP_LAST) begin
                    if (idx_q == IDX_LAST) begin
                        state_d = ST_RUN;
                        done_d  = 1'b1;
                    end else begin
                        idx_d  = idx_q + IW'(1);
                        drst_d = drst_q | (NumDomains'(1) << (idx_q + IW'(1)));
                        gap_d  = '0;
                    end
                end else begin
                    gap_d = gap_q + GW'(1);
                end
            end
            default: begin
                if (req_s || state_q != ST_RUN) begin
                    state_d = ST_ASSERT;
                    drst_d  = '0;
                    done_d  = 1'b0;
                    cnt_d   = '0;
                end
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_ASSERT;
            cnt_q   <= '0;
            gap_q   <= '0;
            idx_q   <= '0;
            drst_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            gap_q   <= gap_d;
            idx_q   <= idx_d;
            drst_q  <= drst_d;
            done_q  <= done_d;
        end
    end

    // Set beats clear so a cause arriving with cause_clr_i is never lost.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rst_cause_o <= {1'b1, {(NumReqs+1){1'b0}}};
        end else begin
            rst_cause_o <= (cause_clr_i ? '0 : rst_cause_o) | {1'b0, sw_rst_req_i, req_sync};
        end
    end

    assign domain_rst_no = drst_q;
    assign rst_done_o    = done_q;
    assign fsm_state     = state_q;

endmodule

// File: tb/tb_rstmgr_seq.sv
// Bench for rstmgr_seq: default instance plus a minimal-parameter instance, both
// checked every cycle against a quiet-cycle timeline model through expected queues.
module tb_rstmgr_seq;

  localparam int ND_A = 4, MH_A = 8, SG_A = 2, SS_A = 2;
  localparam int ND_B = 1, MH_B = 1, SG_B = 1, SS_B = 1;
  localparam int QUIET_MAX = 1000;

  logic       clk = 1'b0;
  logic       rst_i = 1'b1;
  logic [1:0] rst_req = 2'b00;
  logic       sw_req = 1'b0;
  logic       clr = 1'b0;

  logic [3:0] drst_a;
  logic       done_a;
  logic [3:0] cause_a;
  logic [1:0] st_a;
  logic [0:0] drst_b;
  logic       done_b;
  logic [3:0] cause_b;
  logic [1:0] st_b;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [8:0] exp_qa[$];
  logic [5:0] exp_qb[$];

  // clock / reset
  always #5 clk = ~clk;

  rstmgr_seq #(.NumDomains(ND_A), .NumReqs(2), .SyncStages(SS_A), .MinHold(MH_A), .SeqGap(SG_A))
    dut_a (.clk_i(clk), .rst_i(rst_i), .rst_req_i(rst_req), .sw_rst_req_i(sw_req),
           .cause_clr_i(clr), .domain_rst_no(drst_a), .rst_done_o(done_a),
           .rst_cause_o(cause_a), .fsm_state(st_a));

  rstmgr_seq #(.NumDomains(ND_B), .NumReqs(2), .SyncStages(SS_B), .MinHold(MH_B), .SeqGap(SG_B))
    dut_b (.clk_i(clk), .rst_i(rst_i), .rst_req_i(rst_req), .sw_rst_req_i(sw_req),
           .cause_clr_i(clr), .domain_rst_no(drst_b), .rst_done_o(done_b),
           .rst_cause_o(cause_b), .fsm_state(st_b));

  // Domain k is free once the quiet run reaches MinHold + k*SeqGap cycles.
  function automatic logic [3:0] exp_mask(int quiet, int nd, int mh, int sg);
    logic [3:0] m = 4'b0000;
    for (int k = 0; k < nd; k++) if (quiet >= mh + k * sg) m[k] = 1'b1;
    return m;
  endfunction

  // reference model A
  logic [1:0] hist_a[$];
  int         quiet_a = 0;
  logic [3:0] mcause_a = 4'b0000;
  always @(posedge clk) begin
    logic [1:0] synced;
    logic       rs;
    if (rst_i) begin
      hist_a.delete();
      for (int i = 0; i < SS_A; i++) hist_a.push_back(2'b00);
      quiet_a = 0;
      mcause_a = 4'b1000;
    end else begin
      synced = hist_a.pop_front();
      hist_a.push_back(rst_req);
      rs = (|synced) | sw_req;
      mcause_a = (clr ? 4'b0000 : mcause_a) | {1'b0, sw_req, synced};
      if (rs) quiet_a = 0;
      else if (quiet_a < QUIET_MAX) quiet_a = quiet_a + 1;
    end
    exp_qa.push_back({mcause_a, quiet_a >= MH_A + ND_A * SG_A, exp_mask(quiet_a, ND_A, MH_A, SG_A)});
  end

  // reference model B
  logic [1:0] hist_b[$];
  int         quiet_b = 0;
  logic [3:0] mcause_b = 4'b0000;
  always @(posedge clk) begin
    logic [1:0] synced;
    logic       rs;
    logic [3:0] m;
    if (rst_i) begin
      hist_b.delete();
      for (int i = 0; i < SS_B; i++) hist_b.push_back(2'b00);
      quiet_b = 0;
      mcause_b = 4'b1000;
    end else begin
      synced = hist_b.pop_front();
      hist_b.push_back(rst_req);
      rs = (|synced) | sw_req;
      mcause_b = (clr ? 4'b0000 : mcause_b) | {1'b0, sw_req, synced};
      if (rs) quiet_b = 0;
      else if (quiet_b < QUIET_MAX) quiet_b = quiet_b + 1;
    end
    m = exp_mask(quiet_b, ND_B, MH_B, SG_B);
    exp_qb.push_back({mcause_b, quiet_b >= MH_B + ND_B * SG_B, m[0]});
  end

  // monitor / scoreboard
  always @(negedge clk) begin
    logic [8:0] ea;
    logic [5:0] eb;
    cyc++;
    if (exp_qa.size() > 0) begin
      ea = exp_qa.pop_front();
      checks++;
      if ({cause_a, done_a, drst_a} !== ea) begin
        failures++;
        $display("FAIL dut_a cycle=%0d got cause/done/rstn=%b/%b/%b exp=%b/%b/%b",
                 cyc, cause_a, done_a, drst_a, ea[8:5], ea[4], ea[3:0]);
      end
    end
    if (exp_qb.size() > 0) begin
      eb = exp_qb.pop_front();
      checks++;
      if ({cause_b, done_b, drst_b} !== eb) begin
        failures++;
        $display("FAIL dut_b cycle=%0d got cause/done/rstn=%b/%b/%b exp=%b/%b/%b",
                 cyc, cause_b, done_b, drst_b, eb[5:2], eb[1], eb[0]);
      end
    end
  end

  // driver tasks
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic por(input int n);
    rst_i = 1'b1;
    step(n);
    rst_i = 1'b0;
  endtask

  task automatic hold_req(input int b, input int n);
    rst_req[b] = 1'b1;
    step(n);
    rst_req[b] = 1'b0;
  endtask

  task automatic sw_pulse();
    sw_req = 1'b1;
    step(1);
    sw_req = 1'b0;
  endtask

  task automatic clr_pulse();
    clr = 1'b1;
    step(1);
    clr = 1'b0;
  endtask

  initial begin
    // power-on reset and full release
    por(3);
    step(20);
    // external request while running
    hold_req(1, 5);
    step(30);
    // software pulse in the middle of the release sequence
    sw_pulse();
    step(11);
    sw_pulse();
    step(25);
    // clear coinciding with the first synced cycle of rst_req[0]
    rst_req[0] = 1'b1;
    step(1);
    clr = 1'b1;
    step(1);
    clr = 1'b0;
    rst_req[0] = 1'b0;
    step(25);
    // requests toggling faster than MinHold
    for (int i = 0; i < 6; i++) begin
      hold_req(0, 4);
      step(4);
    end
    step(25);
    // randomized traffic
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 5))
        0, 1: step($urandom_range(1, 25));
        2: hold_req($urandom_range(0, 1), $urandom_range(1, 10));
        3: sw_pulse();
        4: clr_pulse();
        default: if ($urandom_range(0, 3) == 0) por($urandom_range(1, 2)); else step(3);
      endcase
    end
    step(25);
    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
